ram_port_arbiter: RTL

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// Each edge it samples the requests, picks at most one winner and registers
// the winner's command onto the RAM port together with a one-cycle grant
// pulse. Read data comes back one cycle after the grant cycle and is steered
// to the requester that issued the read.
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   req0/req1        access requests
//   we0/we1          1 = write, 0 = read (stable while requesting)
//   addr0/addr1      word addresses (stable while requesting)
//   wdata0/wdata1    write data (stable while requesting)
//   gnt0/gnt1        registered one-cycle grant pulses
//   rvalid0/rvalid1  read data valid, one cycle after a read grant
//   rdata0/rdata1    read data, zero whenever the matching rvalid is low
//   ram_we           registered RAM write enable
//   ram_addr         registered RAM address
//   ram_data         registered RAM write data
//   ram_q            RAM read data, valid one cycle after ram_addr
module ram_port_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q
);

  // The address bus must be able to reach every RAM word.
  if (DEPTH > (1 << ADDR_WIDTH)) begin : g_depth_check
    $error("ram_port_arbiter: DEPTH does not fit in ADDR_WIDTH");
  end

  logic [1:0]            req_vec;
  logic [1:0]            elig;
  logic [1:0]            gnt_reg;
  logic [1:0]            gnt_next;
  logic [1:0]            rvalid_reg;
  logic [1:0]            rvalid_next;
  logic                  ptr_reg;      // last winner
  logic                  ptr_next;
  logic                  win_valid;
  logic                  win_sel;
  logic                  ram_we_reg;
  logic                  ram_we_next;
  logic [ADDR_WIDTH-1:0] ram_addr_reg;
  logic [ADDR_WIDTH-1:0] ram_addr_next;
  logic [DATA_WIDTH-1:0] ram_data_reg;
  logic [DATA_WIDTH-1:0] ram_data_next;
  logic [DATA_WIDTH-1:0] rdata_vec [2];

  assign req_vec = {req1, req0};

  // A requester being granted this cycle still holds its request, so it is
  // masked out; this is what limits a lone requester to every other cycle.
  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign elig[gi]      = req_vec[gi] & ~gnt_reg[gi];
    assign rdata_vec[gi] = rvalid_reg[gi] ? ram_q : '0;
  end

  always_comb begin
    win_valid     = |elig;
    // On a tie the requester that did not win last time goes first.
    win_sel       = (elig == 2'b11) ? ~ptr_reg : elig[1];
    gnt_next      = 2'b00;
    ptr_next      = ptr_reg;
    ram_we_next   = 1'b0;
    ram_addr_next = ram_addr_reg;
    ram_data_next = ram_data_reg;
    // The RAM returns data one cycle after the command, i.e. one cycle after
    // the grant cycle, so rvalid trails a read grant by exactly one cycle.
    rvalid_next   = gnt_reg & {2{~ram_we_reg}};
    if (win_valid) begin
      gnt_next      = win_sel ? 2'b10 : 2'b01;
      ptr_next      = win_sel;
      ram_we_next   = win_sel ? we1 : we0;
      ram_addr_next = win_sel ? addr1 : addr0;
      ram_data_next = win_sel ? wdata1 : wdata0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_reg      <= 2'b00;
      rvalid_reg   <= 2'b00;
      ptr_reg      <= 1'b1;   // requester 0 wins the first tie
      ram_we_reg   <= 1'b0;
      ram_addr_reg <= '0;
      ram_data_reg <= '0;
    end else begin
      gnt_reg      <= gnt_next;
      rvalid_reg   <= rvalid_next;
      ptr_reg      <= ptr_next;
      ram_we_reg   <= ram_we_next;
      ram_addr_reg <= ram_addr_next;
      ram_data_reg <= ram_data_next;
    end
  end

  assign gnt0     = gnt_reg[0];
  assign gnt1     = gnt_reg[1];
  assign rvalid0  = rvalid_reg[0];
  assign rvalid1  = rvalid_reg[1];
  assign rdata0   = rdata_vec[0];
  assign rdata1   = rdata_vec[1];
  assign ram_we   = ram_we_reg;
  assign ram_addr = ram_addr_reg;
  assign ram_data = ram_data_reg;

endmodule
